// File: rtl/logs_sum_seq.sv
// Sequential multi-operand summer: LANES addends per cycle into an OBITS accumulator with sticky overflow.
// Optional build macro: LOGS_SUM_SAT_EN (saturate at 2**OBITS-1 instead of modulo wrap).
module logs_sum_seq #(
    parameter int NBITS    = 3,
    parameter int NADDENDS = 8,
    parameter int LANES    = 2,
    parameter int OBITS    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NADDENDS*NBITS-1:0] addends,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OBITS-1:0]          sum,
    output logic                      ovf
);
    localparam int NCHUNK = (NADDENDS + LANES - 1) / LANES;
    localparam int NSLOT  = NCHUNK * LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Wide enough for acc plus a full chunk, so any carry past OBITS is visible.
    localparam int SW     = OBITS + NBITS + $clog2(NADDENDS + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_chunk;
    logic [NBITS-1:0]  r_addends [NADDENDS];
    logic [OBITS-1:0]  r_acc;
    logic              r_ovf;
    logic              r_out_valid;

    logic [NBITS-1:0]  w_slot [NSLOT];
    logic [SW-1:0]     w_chunk_sum;
    logic [SW-1:0]     w_next;
    logic              w_carry;
    logic              w_capture;
    logic              w_last;

    // Lanes past NADDENDS in the final chunk read as zero.
    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < NADDENDS) begin : g_real
            assign w_slot[g] = r_addends[g];
        end else begin : g_pad
            assign w_slot[g] = '0;
        end
    end

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        w_chunk_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_chunk_sum = w_chunk_sum + SW'(w_slot[int'(r_chunk) * LANES + l]);
        end
        w_next  = SW'(r_acc) + w_chunk_sum;
        w_carry = |w_next[SW-1:OBITS];
    end

    assign in_ready  = (r_state == S_IDLE) && !abort;
    assign w_capture = in_valid && in_ready;
    assign w_last    = (r_chunk == CW'(NCHUNK - 1));

    // NOTE: the addend store is pure datapath, only read after a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < NADDENDS; i++) begin
                r_addends[i] <= addends[i*NBITS +: NBITS];
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_chunk     <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_state <= S_ACCUM;
                        r_chunk <= '0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                    end else begin
`ifdef LOGS_SUM_SAT_EN
                        if (r_ovf || w_carry) r_acc <= '1;
                        else                  r_acc <= w_next[OBITS-1:0];
`else
                        r_acc <= w_next[OBITS-1:0];
`endif
                        r_ovf <= r_ovf | w_carry;
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_chunk <= r_chunk + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Abort outranks the output handshake and discards the result.
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                    end else if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_acc;
    assign ovf       = r_ovf;
endmodule
